// File: rtl/aes_pkg.sv
// Shared constants and helpers for the AES-128 encryption core.
package aes_pkg;

  // AES-128 runs ten rounds after the initial key whitening.
  localparam logic [3:0] NUM_ROUNDS = 4'd10;

  // Round constants, indexed directly by round number (1..10).
  // Entry 0 and 11..15 are unused and held at zero.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  // Control state: idle, or running rounds.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } aes_state_e;

  // Multiply by x in GF(2^8), reduction polynomial 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_cipher_if.sv
// Block interface of the AES-128 encryption core.
//
// Handshake: ld is a single-cycle start strobe with no ready; the core always
// accepts it (a ld while busy restarts with the new key/text_in). done is a
// one-cycle valid pulse; text_out is valid on that cycle and is held until
// the next completion or reset. There is no back-pressure on done.
interface aes_cipher_if;
  import aes_pkg::*;

  logic         ld;
  logic [127:0] key;
  logic [127:0] text_in;
  logic         done;
  logic [127:0] text_out;
  aes_state_e   dbg_state;
  logic [3:0]   dbg_round;

  modport master (
    output ld, key, text_in,
    input  done, text_out, dbg_state, dbg_round
  );

  modport slave (
    input  ld, key, text_in,
    output done, text_out, dbg_state, dbg_round
  );
endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box (FIPS-197 table lookup).
module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y = SBOX[x];

endmodule

// File: rtl/aes_cipher.sv
// Iterative AES-128 encryption core: one round per clock, round keys
// expanded on the fly alongside the data path.
module aes_cipher
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  aes_cipher_if.slave bus
);

  aes_state_e   st_q;
  logic [3:0]   round_q;
  logic [127:0] state_q;
  logic [127:0] rkey_q;
  logic [127:0] text_out_q;
  logic         done_q;

  logic [127:0] sb;         // after SubBytes
  logic [127:0] sr;         // after ShiftRows
  logic [127:0] mc;         // after MixColumns
  logic [127:0] next_key;   // round key for round_q
  logic [127:0] round_out;  // state after this round's AddRoundKey
  logic [31:0]  rot_w;
  logic [31:0]  sub_w;
  logic [31:0]  temp_w;
  logic         last;

  // Byte i of the state lives at bits [127-8i -: 8]; column c, row r is i = 4c+r.
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (.x(state_q[127-8*i -: 8]), .y(sb[127-8*i -: 8]));
  end

  // ShiftRows: row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_sr_col
    for (genvar r = 0; r < 4; r++) begin : g_sr_row
      assign sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
    end
  end

  // MixColumns: out_r = 2*a_r ^ 3*a_{r+1} ^ a_{r+2} ^ a_{r+3}.
  for (genvar c = 0; c < 4; c++) begin : g_mc_col
    for (genvar r = 0; r < 4; r++) begin : g_mc_row
      assign mc[127-8*(4*c+r) -: 8] =
          xtime(sr[127-8*(4*c+r) -: 8]) ^
          xtime(sr[127-8*(4*c+(r+1)%4) -: 8]) ^ sr[127-8*(4*c+(r+1)%4) -: 8] ^
          sr[127-8*(4*c+(r+2)%4) -: 8] ^ sr[127-8*(4*c+(r+3)%4) -: 8];
    end
  end

  // Key expansion: RotWord + SubWord of w3, then Rcon for the current round.
  assign rot_w = {rkey_q[23:0], rkey_q[31:24]};
  for (genvar j = 0; j < 4; j++) begin : g_ksbox
    aes_sbox u_ksbox (.x(rot_w[31-8*j -: 8]), .y(sub_w[31-8*j -: 8]));
  end
  assign temp_w = sub_w ^ {RCON[round_q], 24'h000000};
  assign next_key[127:96] = rkey_q[127:96] ^ temp_w;
  assign next_key[95:64]  = rkey_q[95:64]  ^ next_key[127:96];
  assign next_key[63:32]  = rkey_q[63:32]  ^ next_key[95:64];
  assign next_key[31:0]   = rkey_q[31:0]   ^ next_key[63:32];

  assign last      = (round_q == NUM_ROUNDS);
  assign round_out = (last ? sr : mc) ^ next_key;

  // Control and data registers: reset wins, completion is reported even when a
  // new ld lands on the final-round edge, and ld otherwise restarts the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= ST_IDLE;
      round_q    <= 4'd0;
      state_q    <= '0;
      rkey_q     <= '0;
      text_out_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (st_q == ST_RUN && last) begin
        text_out_q <= round_out;
        done_q     <= 1'b1;
      end
      if (bus.ld) begin
        state_q <= bus.text_in ^ bus.key;
        rkey_q  <= bus.key;
        round_q <= 4'd1;
        st_q    <= ST_RUN;
      end else if (st_q == ST_RUN) begin
        rkey_q <= next_key;
        if (last) begin
          round_q <= 4'd0;
          st_q    <= ST_IDLE;
        end else begin
          state_q <= round_out;
          round_q <= round_q + 4'd1;
        end
      end
    end
  end

  assign bus.done      = done_q;
  assign bus.text_out  = text_out_q;
  assign bus.dbg_state = st_q;
  assign bus.dbg_round = round_q;

endmodule

// File: tb/tb_aes_cipher.sv
// Self-checking bench for aes_cipher with a byte-array AES-128 reference model
// whose S-box is derived from GF(2^8) inversion plus the affine transform.
module tb_aes_cipher;
  import aes_pkg::*;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  logic [127:0] exp_q[$];
  logic [7:0]   sbox_t [256];

  aes_cipher_if bus ();

  aes_cipher dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  task automatic build_sbox();
    logic [7:0] x;
    logic [7:0] inv;
    logic [7:0] b;
    for (int v = 0; v < 256; v++) begin
      x = v[7:0];
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 8'h00 && gmul(x, y[7:0]) == 8'h01) inv = y[7:0];
      b = inv;
      sbox_t[v] = inv ^ rotl1(b) ^ rotl1(rotl1(b)) ^ rotl1(rotl1(rotl1(b))) ^
                  rotl1(rotl1(rotl1(rotl1(b)))) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] ct;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]}
              ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          if (rnd < 10)
            s[4*c+r] = gmul(8'h02, t[4*c+r]) ^ gmul(8'h03, t[4*c+(r+1)%4]) ^
                       t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
          else
            s[4*c+r] = t[4*c+r];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
    return ct;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver tasks (called at negedge) ----------------
  task automatic pulse_ld(input logic [127:0] k, input logic [127:0] p);
    bus.ld = 1'b1; bus.key = k; bus.text_in = p;
    @(negedge clk);
    bus.ld = 1'b0;
  endtask

  // Returns the number of negedges until done is seen, or 0 on timeout.
  task automatic wait_done(input int max_cyc, output int cyc);
    cyc = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.ld = 1'b1; bus.key = rand128(); bus.text_in = rand128();
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", bus.done); end
    tests_run++;
    if (bus.text_out !== 128'h0) begin tests_failed++; $display("FAIL reset_text_out: got %h want 0", bus.text_out); end
    tests_run++;
    if (bus.dbg_state !== ST_IDLE || bus.dbg_round !== 4'd0) begin
      tests_failed++; $display("FAIL reset_state: got state=%0d round=%0d want 0/0", bus.dbg_state, bus.dbg_round);
    end
    rst = 1'b0; bus.ld = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fips_c1();
    int cyc;
    logic [127:0] e;
    pulse_ld(C1_KEY, C1_PT);
    exp_q.push_back(aes_model(C1_KEY, C1_PT));
    wait_done(20, cyc);
    tests_run++;
    if (cyc != 10) begin tests_failed++; $display("FAIL c1_latency: got %0d want 10", cyc); end
    tests_run++;
    if (bus.text_out !== C1_CT) begin tests_failed++; $display("FAIL c1_text_out: got %h want %h", bus.text_out, C1_CT); end
    e = exp_q.pop_front();
    tests_run++;
    if (bus.text_out !== e) begin tests_failed++; $display("FAIL c1_model: got %h want %h", bus.text_out, e); end
    @(negedge clk);
    tests_run++;
    if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL c1_done_width: got %b want 0", bus.done); end
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.done !== 1'b0 || bus.text_out !== C1_CT || bus.dbg_state !== ST_IDLE) begin
      tests_failed++; $display("FAIL idle_hold: done=%b text_out=%h want 0/%h", bus.done, bus.text_out, C1_CT);
    end
  endtask

  task automatic test_appendix_b();
    int cyc;
    int extra;
    pulse_ld(B_KEY, B_PT);
    wait_done(20, cyc);
    tests_run++;
    if (cyc != 10 || bus.text_out !== B_CT) begin
      tests_failed++; $display("FAIL appb: got cyc=%0d text_out=%h want 10/%h", cyc, bus.text_out, B_CT);
    end
    extra = 0;
    repeat (12) begin @(negedge clk); if (bus.done === 1'b1) extra++; end
    tests_run++;
    if (extra != 0) begin tests_failed++; $display("FAIL appb_single_pulse: got %0d extra pulses want 0", extra); end
  endtask

  task automatic test_zero_busy_change();
    int cyc;
    pulse_ld(128'h0, 128'h0);
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      bus.key = rand128(); bus.text_in = rand128();
      @(negedge clk);
      if (bus.done === 1'b1) begin cyc = i; break; end
    end
    tests_run++;
    if (cyc != 10 || bus.text_out !== Z_CT) begin
      tests_failed++; $display("FAIL zero_busy: got cyc=%0d text_out=%h want 10/%h", cyc, bus.text_out, Z_CT);
    end
  endtask

  task automatic test_restart();
    int cyc;
    int early;
    pulse_ld(C1_KEY, C1_PT);
    early = 0;
    repeat (4) begin @(negedge clk); if (bus.done === 1'b1) early++; end
    pulse_ld(B_KEY, B_PT);
    wait_done(20, cyc);
    tests_run++;
    if (early != 0 || cyc != 10) begin
      tests_failed++; $display("FAIL restart_timing: got early=%0d cyc=%0d want 0/10", early, cyc);
    end
    tests_run++;
    if (bus.text_out !== B_CT) begin tests_failed++; $display("FAIL restart_text_out: got %h want %h", bus.text_out, B_CT); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    pulse_ld(C1_KEY, C1_PT);
    repeat (5) @(negedge clk);
    tests_run++;
    if (bus.dbg_round !== 4'd6 || bus.dbg_state !== ST_RUN) begin
      tests_failed++; $display("FAIL mid_round: got round=%0d state=%0d want 6/1", bus.dbg_round, bus.dbg_state);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (bus.done !== 1'b0 || bus.text_out !== 128'h0) begin
      tests_failed++; $display("FAIL mid_reset: done=%b text_out=%h want 0/0", bus.done, bus.text_out);
    end
    pulse_ld(C1_KEY, C1_PT);
    wait_done(20, cyc);
    tests_run++;
    if (cyc != 10 || bus.text_out !== C1_CT) begin
      tests_failed++; $display("FAIL post_reset_c1: got cyc=%0d text_out=%h want 10/%h", cyc, bus.text_out, C1_CT);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] k1, p1, k2, p2, e1, e2;
    int bad;
    k1 = rand128(); p1 = rand128(); k2 = rand128(); p2 = rand128();
    pulse_ld(k1, p1);
    exp_q.push_back(aes_model(k1, p1));
    exp_q.push_back(aes_model(k2, p2));
    bad = 0;
    repeat (9) begin @(negedge clk); if (bus.done === 1'b1) bad++; end
    bus.ld = 1'b1; bus.key = k2; bus.text_in = p2;
    @(negedge clk);
    bus.ld = 1'b0;
    e1 = exp_q.pop_front();
    tests_run++;
    if (bad != 0 || bus.done !== 1'b1 || bus.text_out !== e1) begin
      tests_failed++; $display("FAIL b2b_first: early=%0d done=%b text_out=%h want 0/1/%h", bad, bus.done, bus.text_out, e1);
    end
    bad = 0;
    repeat (9) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.text_out !== e1) bad++;
    end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL b2b_hold: got %0d bad cycles want 0", bad); end
    @(negedge clk);
    e2 = exp_q.pop_front();
    tests_run++;
    if (bus.done !== 1'b1 || bus.text_out !== e2) begin
      tests_failed++; $display("FAIL b2b_second: done=%b text_out=%h want 1/%h", bus.done, bus.text_out, e2);
    end
  endtask

  task automatic test_random();
    int cyc;
    int gap;
    int bad;
    logic [127:0] k, p, e;
    for (int n = 0; n < 6; n++) begin
      k = rand128(); p = rand128();
      pulse_ld(k, p);
      exp_q.push_back(aes_model(k, p));
      wait_done(20, cyc);
      e = exp_q.pop_front();
      tests_run++;
      if (cyc != 10 || bus.text_out !== e) begin
        tests_failed++; $display("FAIL random_%0d: got cyc=%0d text_out=%h want 10/%h", n, cyc, bus.text_out, e);
      end
      gap = $urandom_range(1, 4);
      bad = 0;
      repeat (gap) begin @(negedge clk); if (bus.done !== 1'b0 || bus.text_out !== e) bad++; end
      tests_run++;
      if (bad != 0) begin tests_failed++; $display("FAIL random_idle_%0d: got %0d bad cycles want 0", n, bad); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    bus.ld = 1'b0;
    bus.key = '0;
    bus.text_in = '0;
    build_sbox();
    @(negedge clk);
    test_reset();
    test_fips_c1();
    test_appendix_b();
    test_zero_busy_change();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/aes_cipher.md
AES_CIPHER -- requirements
Module: aes_cipher

Interface
REQ-001 The module SHALL have no parameters; AES-128 only, with fixed 128-bit key and block.
REQ-002 clk  input  1  the single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 ld  input  1  start strobe; sampled high on a clk edge, it loads a new block and key.
REQ-005 key  input  128  cipher key; key[127:120] is key byte 0, so word w0 = key[127:96].
REQ-006 text_in  input  128  plaintext; text_in[127:120] is state byte s(0,0); bytes fill the state column-major.
REQ-007 done  output  1  one-cycle pulse marking text_out valid.
REQ-008 text_out  output  128  ciphertext, same byte order as text_in; registered.

Function
REQ-009 The module SHALL implement FIPS-197 AES-128 encryption iteratively, performing one round per clock cycle.
REQ-010 On an edge with ld=1, it SHALL:
- load state <= text_in XOR key (initial AddRoundKey);
- latch key as round key 0;
- set the round counter to 1;
- set busy=1.
REQ-011 On each busy edge with round r in 1..9, it SHALL:
- apply SubBytes, ShiftRows, MixColumns, then AddRoundKey with round key r into the state;
- compute round key r from round key r-1 on the fly (RotWord, SubWord, Rcon[r]).
REQ-012 In round 10, it SHALL omit MixColumns and SHALL write the result to text_out instead of the state.
REQ-013 On the same round-10 edge, it SHALL drive done=1 and clear busy.
- text_out and done therefore appear 10 edges after the ld edge.
- done SHALL be 1 for exactly one cycle.
REQ-014 text_out SHALL hold its value until the next completion or reset.
- It SHALL NOT change during a subsequent operation until that operation's round 10.
REQ-015 key and text_in are sampled only on the ld edge; changes while busy SHALL have no effect.
REQ-016 ld=1 while busy SHALL abort the current operation and restart with the new inputs; no done pulse is issued for the aborted block.
REQ-017 ld=1 on the same edge as round 10 completes SHALL:
- still deliver text_out and the done pulse for the finishing block;
- start the new block on that edge.
REQ-018 While idle with ld=0, all registers SHALL hold and done SHALL be 0.
REQ-019 Rcon for rounds 1..10 SHALL be 01,02,04,08,10,20,40,80,1b,36 (hex).
REQ-020 MixColumns SHALL use GF(2^8) xtime with reduction polynomial 0x11b.

Reset
REQ-021 rst=1 at a clk edge SHALL, taking priority over ld:
- clear done, busy, the round counter, the state, the round key and text_out to 0.
REQ-022 rst asserted mid-operation SHALL abandon the block with no done pulse.
REQ-023 ld in the cycle after rst deasserts SHALL start a normal operation.

Structure
REQ-024 Shared package aes_pkg SHALL hold:
- the Rcon constant table;
- the xtime function;
- the round-count constant (10).
REQ-025 A combinational sub-module aes_sbox (8-bit in, 8-bit out, 256-entry FIPS-197 table) SHALL exist.
- 16 instances serve the data path.
- 4 instances serve key expansion.
REQ-026 ShiftRows, MixColumns and AddRoundKey SHALL be combinational logic within aes_cipher; the state, round key, counter and outputs are the only registers.
REQ-027 Decryption (the inverse cipher) is a separate block; it is out of scope here.

Verification
REQ-028 FIPS-197 C.1 test, covering byte order and latency:
- stimulus: key=000102030405060708090a0b0c0d0e0f, text_in=00112233445566778899aabbccddeeff, one-cycle ld;
- response: done pulses exactly 10 edges later with text_out=69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-029 FIPS-197 Appendix B test:
- stimulus: key=2b7e151628aed2a6abf7158809cf4f3c, text_in=3243f6a8885a308d313198a2e0370734;
- response: text_out=3925841d02dc09fbdc118597196a0b32, one done pulse.
REQ-030 All-zero test:
- stimulus: key=0, text_in=0;
- response: text_out=66e94bd4ef8a2c3b884cfa59ca342b2e.
- Then change key/text_in while busy: the result SHALL be unchanged.
REQ-031 Restart test:
- stimulus: start the C.1 vector, then assert ld at edge 5 with the Appendix B vector;
- response: no done for C.1; done 10 edges after the second ld with 3925841d02dc09fbdc118597196a0b32.
REQ-032 Reset test:
- stimulus: assert rst at round 6;
- response: done=0 and text_out=0 the next cycle and no pulse afterward; a following ld with the C.1 vector completes correctly.
REQ-033 Back-to-back test:
- stimulus: ld with a new vector on the done edge;
- response: the first result is held for 10 cycles, then the second result is delivered with its done pulse.
